// File: rtl/aig_mix_pkg.sv
// +----------------------------------------------------------------------------+
// | aig_mix_pkg                                                                |
// | Shared state encoding and widths for the mixed-AIG datapath sequencer.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package aig_mix_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        SEND0  = 2'd2,
        SEND1  = 2'd3
    } aig_mix_seq_state_e;

    localparam int AIG_MIX_IN_W      = 128;
    localparam int AIG_MIX_OUT_W     = 64;
    localparam int AIG_MIX_WORD_W    = 32;
    localparam int AIG_MIX_IN_BEATS  = 4;
    localparam int AIG_MIX_OUT_BEATS = 2;

endpackage

`default_nettype wire

// File: rtl/aig_mix_seq_if.sv
// +----------------------------------------------------------------------------+
// | aig_mix_seq_if                                                             |
// | One 32-bit valid/ready word stream with a last marker.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface aig_mix_seq_if;
    import aig_mix_pkg::*;

    logic                      valid;
    logic                      ready;
    logic [AIG_MIX_WORD_W-1:0] data;
    logic                      last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

`default_nettype wire

// File: rtl/aig_mix_seq.sv
// +----------------------------------------------------------------------------+
// | aig_mix_seq                                                                |
// | Gathers a 4-beat operand, holds it on the datapath, returns a 2-beat       |
// | result. Revision: 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module aig_mix_seq
    import aig_mix_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    aig_mix_seq_if.slave                  s_if,
    aig_mix_seq_if.master                 m_if,
    output logic [AIG_MIX_IN_W-1:0]       mix_in,
    input  wire logic [AIG_MIX_OUT_W-1:0] mix_out,
    output logic                          err,
    input  wire logic                     err_clr,
    output logic                          busy,
    output logic [15:0]                   vec_cnt
);

    localparam logic [3:0] c_SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    aig_mix_seq_state_e        r_state;
    aig_mix_seq_state_e        w_state_nxt;
    logic [1:0]                r_beat;
    logic [3:0]                r_cnt;
    logic [AIG_MIX_IN_W-1:0]   r_mix_in;
    logic [AIG_MIX_WORD_W-1:0] r_res_hi;
    logic [AIG_MIX_WORD_W-1:0] r_m_data;
    logic                      r_m_last;
    logic                      r_err;
    logic [15:0]               r_vec_cnt;

    logic w_s_ready;
    logic w_m_valid;
    logic w_busy;
    logic w_s_hs;
    logic w_m_hs;
    logic w_last_beat;
    logic w_capture;
    logic w_err_set;

    assign w_s_hs      = s_if.valid & w_s_ready;
    assign w_m_hs      = w_m_valid & m_if.ready;
    assign w_last_beat = (r_beat == 2'd3);
    assign w_capture   = (r_state == SETTLE) && (r_cnt == 4'd0);
    // A last marker is an error exactly when it disagrees with beat 3.
    assign w_err_set   = w_s_hs & (s_if.last ^ w_last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_s_hs && w_last_beat) w_state_nxt = SETTLE;
            SETTLE:  if (r_cnt == 4'd0)         w_state_nxt = SEND0;
            SEND0:   if (m_if.ready)            w_state_nxt = SEND1;
            SEND1:   if (m_if.ready)            w_state_nxt = LOAD;
            default:                            w_state_nxt = LOAD;
        endcase
    end

    always_comb begin
        w_s_ready = (r_state == LOAD);
        w_m_valid = (r_state == SEND0) || (r_state == SEND1);
        w_busy    = !((r_state == LOAD) && (r_beat == 2'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat    <= 2'd0;
            r_cnt     <= 4'd0;
            r_mix_in  <= '0;
            r_res_hi  <= '0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_err     <= 1'b0;
            r_vec_cnt <= 16'd0;
        end else begin
            if (w_s_hs) begin
                r_mix_in[{r_beat, 5'd0} +: AIG_MIX_WORD_W] <= s_if.data;
                // Early last abandons the partial operand; beat 3 wraps to 0.
                r_beat <= (s_if.last && !w_last_beat) ? 2'd0 : r_beat + 2'd1;
            end

            if (w_s_hs && w_last_beat) begin
                r_cnt <= c_SETTLE_INIT;
            end else if ((r_state == SETTLE) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_capture) begin
                r_res_hi <= mix_out[AIG_MIX_OUT_W-1:AIG_MIX_WORD_W];
                r_m_data <= mix_out[AIG_MIX_WORD_W-1:0];
                r_m_last <= 1'b0;
            end else if ((r_state == SEND0) && m_if.ready) begin
                r_m_data <= r_res_hi;
                r_m_last <= 1'b1;
            end

            if ((r_state == SEND1) && w_m_hs) begin
                r_vec_cnt <= r_vec_cnt + 16'd1;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign s_if.ready = w_s_ready;
    assign m_if.valid = w_m_valid;
    assign m_if.data  = r_m_data;
    assign m_if.last  = r_m_last;
    assign mix_in     = r_mix_in;
    assign err        = r_err;
    assign busy       = w_busy;
    assign vec_cnt    = r_vec_cnt;

endmodule

`default_nettype wire

// File: doc/aig_mix_seq.md
# aig_mix_seq

Sequencer for the 128-in/64-out mixed-AIG combinational datapath. It gathers a 128-bit operand from a 32-bit valid/ready input stream (4 beats) and drives it onto the datapath. It holds the operand stable for a programmable settle time, captures the 64-bit result, and returns it as a 2-beat 32-bit valid/ready output stream. It sits between the bus-side word interface and the external mix datapath instance, and also reports framing errors and a completed-vector count.

## Interface
- SETTLE_CYCLES, 1, cycles `mix_in` is held stable before `mix_out` is sampled; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when `s_valid & s_ready`.
- s_data  in  32  operand word; beat k fills `mix_in[32k+31:32k]`.
- s_last  in  1  marks final beat of operand; expected on beat 3 only.
- m_valid  out  1  result beat valid.
- m_ready  in  1  result beat consumed when `m_valid & m_ready`.
- m_data  out  32  result word; beat 0 = `res[31:0]`, beat 1 = `res[63:32]`.
- m_last  out  1  high on result beat 1.
- mix_in  out  128  operand driven to datapath.
- mix_out  in  64  datapath result; combinational function of `mix_in`.
- err  out  1  sticky framing error.
- err_clr  in  1  clears `err`.
- busy  out  1  high in any state other than LOAD with beat count 0.
- vec_cnt  out  16  completed vectors (result beat 1 handshakes), wraps 0xFFFF→0.

## Operation
- States: LOAD, SETTLE, SEND0, SEND1. Reset state is LOAD, beat count 0.
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0, `mix_in`=0, `err`=0, `busy`=0, `vec_cnt`=0, result register=0.
- LOAD:
  - `s_ready`=1. Each handshake writes `s_data` into slice `beat` of `mix_in` and increments `beat`.
  - Handshake with `s_last`=1 on beats 0–2 (early last): set `err`, discard the partial operand, return `beat` to 0. Already-written slices of `mix_in` keep their values.
  - Beat 3 handshake: go to SETTLE with settle counter = SETTLE_CYCLES-1. If `s_last`=0 on this beat, set `err`; the vector is still processed.
- SETTLE:
  - `s_ready`=0, `mix_in` frozen.
  - If counter is 0: capture `mix_out` into the result register at this edge and go to SEND0. Otherwise decrement the counter.
- SEND0: `m_valid`=1, `m_data`=res[31:0], `m_last`=0. On handshake go to SEND1.
- SEND1: `m_valid`=1, `m_data`=res[63:32], `m_last`=1. On handshake increment `vec_cnt`, go to LOAD with `beat`=0.
- `m_valid`, once raised, stays high and `m_data`/`m_last` stay stable until the handshake (AXI-stream rules). `m_data`/`m_last` are registered outputs.
- `err`: a set event and `err_clr` in the same cycle leaves `err`=1. Otherwise `err_clr` clears it next edge.
- `s_ready` is never high outside LOAD. `m_valid` is never high outside SEND0/SEND1. The input and output streams never overlap.

## Timing
- Beat-3 input handshake at edge E0. The result is captured at edge E0+SETTLE_CYCLES. `m_valid` is high from the cycle after that edge.
- Minimum vector period with `m_ready` held at 1: 4 + SETTLE_CYCLES + 2 cycles (7 at default).
- `mix_in` slice k changes only on the edge that accepts beat k.
- `rst_n` asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight operand or result is lost and `vec_cnt` is not incremented.
- `s_valid` low in LOAD: idle, no state change. `m_ready` low in SEND0/SEND1: hold.

## Structure
- Shared package `aig_mix_pkg` holds:
  - state enum `aig_mix_seq_state_e` (LOAD, SETTLE, SEND0, SEND1);
  - constants `AIG_MIX_IN_W`=128, `AIG_MIX_OUT_W`=64, `AIG_MIX_WORD_W`=32, `AIG_MIX_IN_BEATS`=4, `AIG_MIX_OUT_BEATS`=2.
- Single module with no sub-modules. The mix datapath is instantiated alongside it at the parent level, not inside it.

## Test plan
- Nominal, SETTLE_CYCLES=1: send 0x00000001, 0x0, 0x0, 0x80000000 (last on beat 3), bench model drives `mix_out`=0x0123456789ABCDEF. Required: `mix_in`=0x80000000_00000000_00000000_00000001; `m_data` 0x89ABCDEF then 0x01234567 with `m_last`; `m_valid` high 2 cycles after the beat-3 edge; `vec_cnt`=1; `err`=0.
- Early last: `s_last`=1 on beat 1. Required: `err`=1, no output beats, the next 4 clean beats produce exactly one result.
- Missing last on beat 3. Required: `err`=1 and the result is still emitted. `err_clr` pulsed in the same cycle as a new early-last error: `err` remains 1.
- Backpressure: hold `m_ready`=0 for 10 cycles in SEND0. Required: `m_valid`/`m_data` stable, `s_ready`=0 throughout, `mix_in` unchanged.
- SETTLE_CYCLES=15: a `mix_out` change at E0+14 is captured, and a change at E0+16 is not.
- Reset mid-SETTLE and 0xFFFF-vector wrap. Required: after reset all outputs 0 and `s_ready`=1. After 65536 vectors, `vec_cnt`=0.
